// File: rtl/mux2to1_input.sv
// Registered 2:1 operand selector feeding the ripple-adder core: picks pin or test operands.
// Optional macro MUX2TO1_INPUT_SEL_SYNC_EN adds a 2-flop synchronizer on sel.
module mux2to1_input #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pin_a,
  input  logic [N-1:0] pin_b,
  input  logic         pin_cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sel,
  output logic [N-1:0] sel_a,
  output logic [N-1:0] sel_b,
  output logic         sel_cin,
  output logic         sel_eff
);

  logic         s;
  logic [N-1:0] nxt_a;
  logic [N-1:0] nxt_b;
  logic         nxt_cin;

`ifdef MUX2TO1_INPUT_SEL_SYNC_EN
  logic sel_meta;
  logic sel_sync;

  // sel may come from an unrelated test domain; only sel_sync is ever used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
    end else begin
      sel_meta <= sel;
      sel_sync <= sel_meta;
    end
  end

  assign s = sel_sync;
`else
  assign s = sel;
`endif

  // One select steers all three fields so a word never mixes sources.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    nxt_a   = pin_a;
    nxt_b   = pin_b;
    nxt_cin = pin_cin;
    if (s) begin
      nxt_a   = a;
      nxt_b   = b;
      nxt_cin = cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a   <= '0;
      sel_b   <= '0;
      sel_cin <= 1'b0;
      sel_eff <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers see pre-edge values.
      sel_a   <= nxt_a;
      sel_b   <= nxt_b;
      sel_cin <= nxt_cin;
      sel_eff <= s;
    end
  end

endmodule

// File: tb/tb_mux2to1_input.sv
// Scoreboard bench for mux2to1_input: driver pushes expected words, monitor pops after each edge.
// Define MUX2TO1_INPUT_SEL_SYNC_EN for both bench and RTL to check the synchronized build.
module tb_mux2to1_input;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pin_a, pin_b, a, b;
  logic         pin_cin, cin, sel;
  logic [N-1:0] sel_a, sel_b;
  logic         sel_cin, sel_eff;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         eff;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] pa;
    logic [N-1:0] pb;
    logic         pc;
    logic [N-1:0] ta;
    logic [N-1:0] tb;
    logic         tc;
    logic         s;
  } vec_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   started = 1'b0;
  bit   done = 1'b0;
  logic h1, h2;  // sel sampled one and two edges back (sync build model)

  mux2to1_input #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .pin_a(pin_a), .pin_b(pin_b), .pin_cin(pin_cin),
    .a(a), .b(b), .cin(cin), .sel(sel),
    .sel_a(sel_a), .sel_b(sel_b), .sel_cin(sel_cin), .sel_eff(sel_eff)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 64'(sel_a), 64'h0);
    check({tag, "_b"}, 64'(sel_b), 64'h0);
    check({tag, "_cin"}, 64'(sel_cin), 64'h0);
    check({tag, "_eff"}, 64'(sel_eff), 64'h0);
  endtask

  task automatic set_vec(input vec_t v);
    pin_a = v.pa; pin_b = v.pb; pin_cin = v.pc;
    a = v.ta; b = v.tb; cin = v.tc; sel = v.s;
  endtask

  // Expected word for the coming edge, from the inputs currently driven.
  task automatic push_expect();
    exp_t e;
    logic s;
    check("sel_known", 64'(!$isunknown(sel)), 64'h1);
`ifdef MUX2TO1_INPUT_SEL_SYNC_EN
    s = h2;
`else
    s = sel;
`endif
    e.a   = s ? a : pin_a;
    e.b   = s ? b : pin_b;
    e.cin = s ? cin : pin_cin;
    e.eff = s;
    sb_q.push_back(e);
    h2 = h1;
    h1 = sel;
  endtask

  task automatic apply(input vec_t v);
    set_vec(v);
    push_expect();
    @(negedge clk);
  endtask

  // Monitor: one output word per edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started && !rst && !done) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(sb_q.size()), 64'h1);
        end else begin
          e = sb_q.pop_front();
          check("sel_a", 64'(sel_a), 64'(e.a));
          check("sel_b", 64'(sel_b), 64'(e.b));
          check("sel_cin", 64'(sel_cin), 64'(e.cin));
          check("sel_eff", 64'(sel_eff), 64'(e.eff));
        end
      end
    end
  end

  initial begin
    vec_t pin0, alt1, alt_a5;
    pin0   = '{pa:16'h0000, pb:16'h0000, pc:1'b0, ta:16'hFFFF, tb:16'hFFFF, tc:1'b1, s:1'b0};
    alt1   = '{pa:16'h0000, pb:16'h0000, pc:1'b0, ta:16'hFFFF, tb:16'hFFFF, tc:1'b1, s:1'b1};
    alt_a5 = '{pa:16'h0000, pb:16'h0000, pc:1'b0, ta:16'hA5A5, tb:16'hFFFF, tc:1'b1, s:1'b1};

    // Async reset with live functional inputs present.
    rst = 1'b0;
    set_vec('{pa:16'h1234, pb:16'h5678, pc:1'b1, ta:16'h9ABC, tb:16'hDEF0, tc:1'b1, s:1'b1});
    #1 rst = 1'b1;
    #1 check_zero("rst_async");
    repeat (2) @(posedge clk);
    #1 check_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    h1 = 1'b0; h2 = 1'b0;
    started = 1'b1;
    #1 check_zero("rst_release");
    apply(pin0);
    apply(pin0);

    // Pin path then alternate path, held long enough for the synchronized build.
    repeat (3) apply(pin0);
    repeat (3) apply(alt1);

    // sel 0->1 and a change together; next word is entirely alternate.
    repeat (3) apply(pin0);
    apply(alt_a5);
    apply(alt_a5);
    apply(alt_a5);

    // Toggle sel each cycle with distinct data on both paths.
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.pa = 16'h1000 + 16'(i);
      v.pb = 16'h2000 + 16'(i);
      v.pc = i[0];
      v.ta = 16'hC000 + 16'(i);
      v.tb = 16'hD000 + 16'(i);
      v.tc = ~i[0];
      v.s  = ~i[0];
      apply(v);
    end

    // Mid-cycle reset pulse while sel=1; resumes from whatever path the select reaches.
    set_vec(alt1);
    #1 rst = 1'b1;
    #1 check_zero("rst_mid");
    #1 rst = 1'b0;
    h1 = 1'b0; h2 = 1'b0;
    check_zero("rst_mid_release");
    push_expect();
    @(negedge clk);
    repeat (3) apply(alt1);
    apply(pin0);

    done = 1'b1;
    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
